// File: rtl/dsi_long_pkt_engine.sv
// DSI packet engine: header + payload + CRC-16, striped across NUM_LANES byte lanes.
// Optional short-packet support is compiled in with DSI_SHORT_PKT_EN.
module dsi_long_pkt_engine #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned WC_W      = 16,
    localparam int unsigned LW       = NUM_LANES * 8
) (
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cfg_vc,
    input  logic [5:0]           cfg_dt,
    input  logic [WC_W-1:0]      cfg_wc,
    output logic                 busy,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [LW-1:0]        m_data,
    output logic [NUM_LANES-1:0] m_strb,
    output logic                 m_sop,
    output logic                 m_eop,
    input  logic                 m_ready
);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [2:0] {IDLE, HDR, PLD, CRC, FLUSH} state_t;

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             idx_q;
    logic [1:0]             vc_q;
    logic [5:0]             dt_q;
    logic [WC_W-1:0]        wc_cfg_q, wc_q;
    logic [15:0]            crc_q;
    logic [LW-1:0]          acc_q;
    logic [LANE_W-1:0]      lane_q;
    logic                   sop_pend_q;
    logic                   busy_q;
    logic                   prod_en, start_acc, byte_vld, byte_last, flush_fire;
    logic [7:0]             byte_val;
    logic [5:0]             hdr_ecc;
    logic [NUM_LANES-1:0]   strb_part;
`ifdef DSI_SHORT_PKT_EN
    logic                   short_q;
`endif

    assign busy      = busy_q;
    assign prod_en   = !m_valid || m_ready;
    assign start_acc = (state_q == IDLE) && start && !busy_q;
    assign hdr_ecc   = ecc6({wc_cfg_q[15:0], vc_q, dt_q});
    assign flush_fire = (state_q == FLUSH) && (lane_q != '0) && prod_en;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) strb_part[i] = (i < int'(lane_q));
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Byte producer: selects the next packet byte and sequences the FSM.
    always_comb begin
        state_d   = state_q;
        byte_vld  = 1'b0;
        byte_val  = 8'h00;
        byte_last = 1'b0;
        s_ready   = 1'b0;
        case (state_q)
            IDLE: if (start_acc) state_d = HDR;
            HDR: begin
                byte_vld = prod_en;
                case (idx_q)
                    2'd0:    byte_val = {vc_q, dt_q};
                    2'd1:    byte_val = wc_cfg_q[7:0];
                    2'd2:    byte_val = wc_cfg_q[15:8];
                    default: byte_val = {2'b00, hdr_ecc};
                endcase
                if (prod_en && idx_q == 2'd3) begin
`ifdef DSI_SHORT_PKT_EN
                    if (short_q) begin
                        byte_last = 1'b1;
                        state_d   = FLUSH;
                    end else if (wc_q == '0) state_d = CRC;
                    else                     state_d = PLD;
`else
                    if (wc_q == '0) state_d = CRC;
                    else            state_d = PLD;
`endif
                end
            end
            PLD: begin
                s_ready  = prod_en;
                byte_vld = s_valid && prod_en;
                byte_val = s_data;
                if (byte_vld && wc_q == WC_W'(1)) state_d = CRC;
            end
            CRC: begin
                byte_vld = prod_en;
                byte_val = idx_q[0] ? crc_q[15:8] : crc_q[7:0];
                if (prod_en && idx_q[0]) begin
                    byte_last = 1'b1;
                    state_d   = FLUSH;
                end
            end
            FLUSH: if (lane_q == '0 || prod_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet context, counters and CRC.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            vc_q     <= '0;
            dt_q     <= '0;
            wc_cfg_q <= '0;
            wc_q     <= '0;
            crc_q    <= 16'hFFFF;
            busy_q   <= 1'b0;
`ifdef DSI_SHORT_PKT_EN
            short_q  <= 1'b0;
`endif
        end else begin
            if (state_d != state_q)                                   idx_q <= '0;
            else if (byte_vld && (state_q == HDR || state_q == CRC))  idx_q <= idx_q + 2'd1;
            if (start_acc) begin
                vc_q     <= cfg_vc;
                dt_q     <= cfg_dt;
                wc_cfg_q <= cfg_wc;
                wc_q     <= cfg_wc;
                crc_q    <= 16'hFFFF;
                busy_q   <= 1'b1;
`ifdef DSI_SHORT_PKT_EN
                short_q  <= (cfg_dt[5:4] == 2'b00);
`endif
            end else if (m_valid && m_ready && m_eop) begin
                busy_q <= 1'b0;
            end
            if (state_q == PLD && byte_vld) begin
                wc_q  <= wc_q - WC_W'(1);
                crc_q <= crc_step(crc_q, s_data);
            end
        end
    end

    // Lane accumulator and registered output beat.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            lane_q     <= '0;
            sop_pend_q <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_strb     <= '0;
            m_sop      <= 1'b0;
            m_eop      <= 1'b0;
        end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (start_acc) sop_pend_q <= 1'b1;
            if (byte_vld) begin
                if (lane_q == LAST_LANE) begin
                    m_data     <= acc_q | (LW'(byte_val) << {lane_q, 3'b000});
                    m_strb     <= '1;
                    m_sop      <= sop_pend_q;
                    m_eop      <= byte_last;
                    m_valid    <= 1'b1;
                    acc_q      <= '0;
                    lane_q     <= '0;
                    sop_pend_q <= 1'b0;
                end else begin
                    acc_q  <= acc_q | (LW'(byte_val) << {lane_q, 3'b000});
                    lane_q <= lane_q + LANE_W'(1);
                end
            end else if (flush_fire) begin
                m_data     <= acc_q;
                m_strb     <= strb_part;
                m_sop      <= sop_pend_q;
                m_eop      <= 1'b1;
                m_valid    <= 1'b1;
                acc_q      <= '0;
                lane_q     <= '0;
                sop_pend_q <= 1'b0;
            end
        end
    end
endmodule
